// File: rtl/noc_local_ni_if.sv
// Bundle between a neuron core, the local network interface and router local port 0.
// slave = the network interface, master = the core/router side driving it.
interface noc_local_ni_if #(
  parameter int unsigned FW = 36,
  parameter int unsigned B  = 4,
  parameter int unsigned XW = 4,
  parameter int unsigned YW = 4
);
  localparam int unsigned PW = FW - XW - YW;
  localparam int unsigned CW = $clog2(B) + 1;

  // core TX side
  logic          tx_valid;
  logic          tx_ready;
  logic [XW-1:0] tx_dx;
  logic [YW-1:0] tx_dy;
  logic [PW-1:0] tx_payload;
  // router local input
  logic          flit_out_wr;
  logic [FW-1:0] flit_out;
  logic          credit_in;
  // router local output
  logic          flit_in_wr;
  logic [FW-1:0] flit_in;
  logic          credit_out;
  // core RX side
  logic          rx_valid;
  logic          rx_ready;
  logic [PW-1:0] rx_payload;
  logic [CW-1:0] rx_count;
  // sticky protocol errors
  logic          err_overflow;
  logic          err_credit;

  modport slave (
    input  tx_valid, tx_dx, tx_dy, tx_payload, credit_in, flit_in_wr, flit_in, rx_ready,
    output tx_ready, flit_out_wr, flit_out, credit_out, rx_valid, rx_payload, rx_count,
           err_overflow, err_credit
  );

  modport master (
    output tx_valid, tx_dx, tx_dy, tx_payload, credit_in, flit_in_wr, flit_in, rx_ready,
    input  tx_ready, flit_out_wr, flit_out, credit_out, rx_valid, rx_payload, rx_count,
           err_overflow, err_credit
  );
endinterface

// File: rtl/noc_local_ni.sv
// Local network interface: credit-flow-controlled TX flit injection and a B-deep RX
// FIFO that returns one credit to the router per flit popped by the core.
module noc_local_ni #(
  parameter int unsigned FW = 36,
  parameter int unsigned B  = 4,
  parameter int unsigned XW = 4,
  parameter int unsigned YW = 4
) (
  input  logic           clk,
  input  logic           rst,
  noc_local_ni_if.slave  bus
);
  localparam int unsigned PW = FW - XW - YW;
  localparam int unsigned AW = $clog2(B);
  localparam int unsigned CW = AW + 1;

  // ---------------- TX path ----------------
  logic [CW-1:0] tx_cnt;
  logic          tx_ready_c;
  logic          tx_hs_c;
  logic          err_credit_q;
  logic          flit_wr_q;
  logic [FW-1:0] flit_q;

  assign tx_ready_c = (tx_cnt != '0);
  assign tx_hs_c    = bus.tx_valid & tx_ready_c;

  // Credit counter; a handshake and a returned credit in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt       <= CW'(B);
      err_credit_q <= 1'b0;
    end else if (tx_hs_c && !bus.credit_in) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else if (!tx_hs_c && bus.credit_in) begin
      if (tx_cnt == CW'(B)) err_credit_q <= 1'b1;
      else                  tx_cnt       <= tx_cnt + CW'(1);
    end
  end

  // Flit launch register; flit_out holds its last value between launches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_wr_q <= 1'b0;
      flit_q    <= '0;
    end else begin
      flit_wr_q <= tx_hs_c;
      if (tx_hs_c) flit_q <= {bus.tx_dx, bus.tx_dy, bus.tx_payload};
    end
  end

  // ---------------- RX path ----------------
  logic [PW-1:0] mem [B];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] rx_cnt;
  logic          credit_q;
  logic          err_overflow_q;
  logic          rx_full_c;
  logic          rx_valid_c;
  logic          pop_c;
  logic          push_c;
  logic          overflow_c;
  logic          unused_route;

  // Routing fields are spent by the time a flit reaches its destination.
  assign unused_route = ^bus.flit_in[FW-1:PW];

  assign rx_full_c  = (rx_cnt == CW'(B));
  assign rx_valid_c = (rx_cnt != '0);
  assign pop_c      = rx_valid_c & bus.rx_ready;
  // A pop on a full FIFO frees the slot in time for the same-cycle push.
  assign push_c     = bus.flit_in_wr & (~rx_full_c | pop_c);
  assign overflow_c = bus.flit_in_wr & rx_full_c & ~pop_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rx_cnt         <= '0;
      credit_q       <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      credit_q <= pop_c;
      if (push_c) wr_ptr <= wr_ptr + CW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + CW'(1);
      if (push_c && !pop_c)      rx_cnt <= rx_cnt + CW'(1);
      else if (!push_c && pop_c) rx_cnt <= rx_cnt - CW'(1);
      if (overflow_c) err_overflow_q <= 1'b1;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[AW-1:0]] <= bus.flit_in[PW-1:0];
  end

  assign bus.tx_ready     = tx_ready_c;
  assign bus.flit_out_wr  = flit_wr_q;
  assign bus.flit_out     = flit_q;
  assign bus.credit_out   = credit_q;
  assign bus.rx_valid     = rx_valid_c;
  assign bus.rx_payload   = mem[rd_ptr[AW-1:0]];
  assign bus.rx_count     = rx_cnt;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_credit   = err_credit_q;
endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Network interface between a neuron core and the router's local port (port 0).
- TX path: packs core spike events into flits and injects them into the router's local input, using credit-based flow control against the router's input buffer depth B.
- RX path: buffers flits that the router delivers on its local output in a B-deep FIFO. Returns one credit to the router per flit consumed by the core.

Parameters:
- FW, 36, flit width in bits.
- B, 4, router input buffer depth; sets the initial TX credits and the RX FIFO depth (power of 2, ≥2).
- XW, 4, dx field width.
- YW, 4, dy field width.
- PW, FW-XW-YW, payload width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- tx_valid  in  1  core has an event.
- tx_ready  out  1  NI accepts the event this cycle.
- tx_dx  in  XW  signed relative x destination.
- tx_dy  in  YW  signed relative y destination.
- tx_payload  in  PW  event payload (neuron id / axon).
- flit_out_wr  out  1  flit valid toward the router local input.
- flit_out  out  FW  flit toward the router.
- credit_in  in  1  one-cycle pulse from the router: one local input slot freed.
- flit_in_wr  in  1  flit valid from the router local output.
- flit_in  in  FW  flit from the router.
- credit_out  out  1  one-cycle pulse to the router: one RX slot freed.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  core pops the RX head.
- rx_payload  out  PW  payload of the RX head.
- rx_count  out  $clog2(B)+1  RX FIFO occupancy.
- err_overflow  out  1  sticky: a flit arrived while the RX FIFO was full.
- err_credit  out  1  sticky: credit_in arrived while the credit count was already B.

Behaviour:
- Flit format: flit[FW-1 -: XW]=dx, next YW bits=dy, low PW bits=payload. The RX side ignores dx/dy (they are zero on arrival).
- Reset values: flit_out_wr=0, flit_out=0, credit_out=0, err_*=0, RX FIFO empty (rx_valid=0, rx_count=0), credit count=B.
- TX credit counter, range 0..B:
  - tx_ready = (cnt != 0), combinational from the register only; no path from tx_valid.
  - A TX handshake (tx_valid & tx_ready) decrements the count.
  - credit_in increments the count.
  - Both in the same cycle: count unchanged.
  - credit_in at cnt==B with no handshake: count holds at B, err_credit set.
- TX output register:
  - On a handshake in cycle N, flit_out_wr=1 in cycle N+1 with flit_out={tx_dx,tx_dy,tx_payload}.
  - Otherwise flit_out_wr=0; flit_out holds its last value.
  - Back-to-back handshakes give back-to-back flits; throughput is 1 flit/cycle while credits remain.
- RX FIFO: B entries; read and write pointers are $clog2(B)+1 bits, wrapping naturally.
  - Write when flit_in_wr and not full.
  - flit_in_wr while full: flit dropped, err_overflow set, no state change.
  - Read when rx_valid & rx_ready. rx_payload is combinational from the head entry.
  - Simultaneous push and pop when full: the pop frees the slot first, so the push is accepted and there is no error.
  - Simultaneous push and pop when empty: the push is stored and the pop is ignored (rx_valid was 0).
  - rx_count updates in the same edge: +1, -1, or unchanged on simultaneous push and pop.
- credit_out is registered and pulses for exactly 1 cycle in cycle N+1 for each pop in cycle N. Consecutive pops give consecutive pulses.
- The router never overruns a correctly credited NI. err_overflow therefore flags protocol violation only.
- Error flags clear only on rst.
- rst asserted mid-operation:
  - All state returns to reset values immediately (async).
  - In-flight flits and pending credits are discarded.
  - The router must be reset in the same window.

Test Plan:
- Reset, then 6 back-to-back tx_valid with no credit_in (B=4) -> exactly 4 handshakes, flit_out_wr high for 4 consecutive cycles starting 1 cycle after the first, then tx_ready=0.
- From cnt=0, pulse credit_in once -> tx_ready=1 next cycle. A handshake in that cycle returns cnt to 0. credit_in and a handshake in the same cycle at cnt=2 -> cnt stays 2.
- Send tx_dx=4'hF, tx_dy=4'h1, tx_payload=28'h0ABCDEF -> flit_out=36'hF1_0ABCDEF.
- Write 4 flits with rx_ready=0 -> rx_count=4. A 5th write -> dropped, err_overflow=1, rx_count=4. Then pop all with rx_ready=1 -> payloads in arrival order, 4 consecutive credit_out pulses each 1 cycle after its pop.
- FIFO full with push and pop in the same cycle -> rx_count stays 4, err_overflow stays 0, the new flit appears at the tail.
- Assert rst with 2 RX entries and cnt=1 -> rx_valid=0, rx_count=0, credit_out=0, tx_ready=1 (cnt=4) before the next clock edge.
